// File: rtl/branch_target_unit_if.sv
// Request/response bundle for branch_target_unit.
//   Request (master -> slave): estado_pc, imm_gen, rs1_val, mode, in_valid,
//                              stall, flush
//   Response (slave -> master): entrada_mux, link_addr, out_valid,
//                               misaligned, ras_hit, ras_empty, ras_full
// The fetch-stage driver uses the master modport; the target unit uses slave.
interface branch_target_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] estado_pc;
    logic [XLEN-1:0] imm_gen;
    logic [XLEN-1:0] rs1_val;
    logic [2:0]      mode;
    logic            in_valid;
    logic            stall;
    logic            flush;

    logic [XLEN-1:0] entrada_mux;
    logic [XLEN-1:0] link_addr;
    logic            out_valid;
    logic            misaligned;
    logic            ras_hit;
    logic            ras_empty;
    logic            ras_full;

    modport master (
        output estado_pc, imm_gen, rs1_val, mode, in_valid, stall, flush,
        input  entrada_mux, link_addr, out_valid, misaligned, ras_hit,
               ras_empty, ras_full
    );

    modport slave (
        input  estado_pc, imm_gen, rs1_val, mode, in_valid, stall, flush,
        output entrada_mux, link_addr, out_valid, misaligned, ras_hit,
               ras_empty, ras_full
    );
endinterface

// File: rtl/branch_target_unit.sv
// Next-PC target generator for the fetch stage.
// Computes SEQ / BRANCH / JAL / JALR / RET targets in PC units, keeps a
// circular return-address stack, and registers the result one cycle after
// an accepted request.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset
//   bus    - branch_target_unit_if slave: request inputs, registered
//            target/link/flags, combinational RAS empty/full
module branch_target_unit #(
    parameter int XLEN      = 32,
    parameter int IMM_SHIFT = 2,
    parameter int PC_STEP   = 1,
    parameter int RAS_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    branch_target_unit_if.slave   bus
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Bits below PC granularity; empty mask when the PC is byte-addressed,
    // which makes the misaligned flag constant zero.
    localparam logic [XLEN-1:0] LOW_MASK =
        XLEN'((64'd1 << IMM_SHIFT) - 64'd1);

    typedef enum logic [2:0] {
        MODE_SEQ    = 3'd0,
        MODE_BRANCH = 3'd1,
        MODE_JAL    = 3'd2,
        MODE_JALR   = 3'd3,
        MODE_RET    = 3'd4
    } mode_e;

    // Registered outputs
    logic [XLEN-1:0] target_reg;
    logic [XLEN-1:0] link_reg;
    logic            valid_reg;
    logic            misaligned_reg;
    logic            hit_reg;

    // Return-address stack: top_ptr_reg addresses the most recent entry
    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Next-state values
    logic [XLEN-1:0] seq_target;
    logic [XLEN-1:0] imm_units;
    logic [XLEN-1:0] rel_target;
    logic [XLEN-1:0] jalr_byte;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] target_next;
    logic            misaligned_next;
    logic            hit_next;
    logic            push;
    logic            pop;
    logic            accept;
    logic            empty;
    logic            full;
    logic [PTR_W-1:0] push_ptr;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(RAS_DEPTH));
    assign accept   = bus.in_valid && !bus.stall && !bus.flush;
    assign push_ptr = top_ptr_reg + PTR_W'(1);

    always_comb begin
        seq_target      = bus.estado_pc + XLEN'(PC_STEP);
        imm_units       = XLEN'($signed(bus.imm_gen) >>> IMM_SHIFT);
        rel_target      = bus.estado_pc + imm_units;
        jalr_byte       = (bus.rs1_val + bus.imm_gen) & ~XLEN'(1);
        jalr_target     = jalr_byte >> IMM_SHIFT;

        target_next     = seq_target;
        misaligned_next = 1'b0;
        hit_next        = 1'b0;
        push            = 1'b0;
        pop             = 1'b0;

        case (bus.mode)
            MODE_BRANCH: begin
                target_next     = rel_target;
                misaligned_next = |(bus.imm_gen & LOW_MASK);
            end
            MODE_JAL: begin
                target_next     = rel_target;
                misaligned_next = |(bus.imm_gen & LOW_MASK);
                push            = 1'b1;
            end
            MODE_JALR: begin
                target_next     = jalr_target;
                misaligned_next = |(jalr_byte & LOW_MASK);
            end
            MODE_RET: begin
                if (!empty) begin
                    target_next = ras_mem[top_ptr_reg];
                    hit_next    = 1'b1;
                    pop         = 1'b1;
                end else begin
                    // Nothing predicted: fall back to the architectural JALR
                    target_next     = jalr_target;
                    misaligned_next = |(jalr_byte & LOW_MASK);
                end
            end
            default: begin
                target_next = seq_target;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            target_reg     <= '0;
            link_reg       <= '0;
            valid_reg      <= 1'b0;
            misaligned_reg <= 1'b0;
            hit_reg        <= 1'b0;
            top_ptr_reg    <= '0;
            count_reg      <= '0;
        end else if (!bus.stall) begin
            if (bus.flush || !bus.in_valid) begin
                valid_reg <= 1'b0;
            end else begin
                target_reg     <= target_next;
                link_reg       <= seq_target;
                valid_reg      <= 1'b1;
                misaligned_reg <= misaligned_next;
                hit_reg        <= hit_next;
                if (push) begin
                    // When full the pointer still advances, so the slot
                    // written is the oldest one and count saturates.
                    top_ptr_reg <= push_ptr;
                    if (!full) begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end else if (pop) begin
                    top_ptr_reg <= top_ptr_reg - PTR_W'(1);
                    count_reg   <= count_reg - CNT_W'(1);
                end
            end
        end
    end

    // Entry storage carries no reset; contents are only read when count > 0.
    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
            always_ff @(posedge clock) begin
                if (accept && push && (push_ptr == PTR_W'(gi))) begin
                    ras_mem[gi] <= seq_target;
                end
            end
        end
    endgenerate

    assign bus.entrada_mux = target_reg;
    assign bus.link_addr   = link_reg;
    assign bus.out_valid   = valid_reg;
    assign bus.misaligned  = misaligned_reg;
    assign bus.ras_hit     = hit_reg;
    assign bus.ras_empty   = empty;
    assign bus.ras_full    = full;

endmodule

// File: doc/branch_target_unit.md
Name: branch_target_unit

Overview:
Parametrised next-PC target generator for the fetch stage. It replaces the single-mode PC+offset adder and adds:
- sequential, branch, JAL, JALR and return modes;
- signed immediates and a configurable PC addressing granularity;
- a return-address stack (RAS);
- a registered target with valid/stall/flush control.

Its output drives the PC-select mux input; the target appears one cycle after an accepted request.

Parameters:
XLEN, 32, datapath width of PC, immediate, rs1 and all target/link outputs
IMM_SHIFT, 2, arithmetic right shift applied to byte offsets to convert them to PC units (2 = word-addressed PC, 0 = byte-addressed)
PC_STEP, 1, sequential increment in PC units (1 for word-addressed, 4 for byte-addressed)
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
estado_pc  in  XLEN  current PC (PC units)
imm_gen  in  XLEN  sign-extended immediate (byte offset)
rs1_val  in  XLEN  JALR base register (byte address)
mode  in  3  0 SEQ, 1 BRANCH, 2 JAL, 3 JALR, 4 RET, 5-7 treated as SEQ
in_valid  in  1  request accepted when high and stall low
stall  in  1  freeze all state
flush  in  1  invalidate output
entrada_mux  out  XLEN  registered target (PC units)
link_addr  out  XLEN  registered estado_pc + PC_STEP of the accepted request
out_valid  out  1  entrada_mux/link_addr valid
misaligned  out  1  registered alignment fault for the held target
ras_hit  out  1  registered: RET was served from the RAS
ras_empty  out  1  combinational, count == 0
ras_full  out  1  combinational, count == RAS_DEPTH

Behaviour:
- Reset (asynchronous):
  - entrada_mux, link_addr = 0.
  - out_valid, misaligned, ras_hit = 0.
  - RAS pointer and count = 0; entry contents don't-care.
- Latency: a request accepted at edge N has its results visible after edge N.
- Priority per rising edge: reset > stall > flush > in_valid.
  - stall=1: no register or RAS changes, including when flush=1.
  - flush=1 (stall=0): out_valid<=0; target, link, RAS unchanged; in_valid ignored.
  - in_valid=0 (no stall/flush): out_valid<=0; other outputs hold.
- Arithmetic: all sums wrap modulo 2^XLEN; `>>>` is arithmetic (signed).
  - SEQ: target = pc + PC_STEP.
  - BRANCH: target = pc + (imm >>> IMM_SHIFT).
  - JAL: target as BRANCH. Push link (pc + PC_STEP) onto the RAS.
  - JALR: byte = (rs1 + imm) with bit0 cleared; target = byte >> IMM_SHIFT (logical).
  - RET, RAS non-empty: target = top entry; pop; ras_hit<=1.
  - RET, RAS empty: target computed as JALR; RAS unchanged; ras_hit<=0.
- ras_hit is 0 for every mode other than RET.
- misaligned (IMM_SHIFT>0 only; otherwise always 0):
  - BRANCH/JAL: imm[IMM_SHIFT-1:0] != 0.
  - JALR and RET-miss: byte[IMM_SHIFT-1:0] != 0.
  - SEQ and RET-hit: 0.
  - The target is still produced (low bits discarded); the flag is only reported.
- RAS:
  - Circular buffer.
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop decrements count and moves the top pointer.
  - Only one RAS operation per cycle, and only for an accepted request.
- Outputs are held while stall=1, and after out_valid drops, until the next accepted request.
- Reset mid-operation clears the RAS immediately. The first edge after reset deassertion behaves as normal.

Test Plan:
1. Reset asserted mid-request → all outputs 0 immediately, ras_empty=1. Release, then SEQ with pc=0x10 → entrada_mux=0x11, link_addr=0x11, out_valid=1 one cycle later.
2. BRANCH, pc=0x100, imm=0xFFFFFFF8 (-8), IMM_SHIFT=2 → entrada_mux=0xFE, misaligned=0. Same with imm=6 → entrada_mux=0x101, misaligned=1.
3. JAL at pc=0x20 (imm=0x40), then RET → JAL target 0x30, link 0x21; RET target 0x21, ras_hit=1, ras_empty=1 afterwards.
4. Five JALs with RAS_DEPTH=4 at pc=1..5, then five RETs → RET targets 6,5,4,3 with ras_hit=1. Fifth RET uses JALR path (rs1=0x80, imm=0 → 0x20), ras_hit=0.
5. JALR rs1=0x103, imm=0 → byte 0x102, entrada_mux=0x40, misaligned=1. Wrap case: BRANCH pc=0xFFFFFFFF, imm=4 → entrada_mux=0x00000000.
6. stall=1 with in_valid=1, mode=JAL for 3 cycles → outputs and ras count unchanged. stall=1 with flush=1 → out_valid held. Then flush=1 and in_valid=1 → out_valid=0, RAS count unchanged.
